// File: rtl/spi_ram_pkg.sv
// Shared opcode and FSM encodings for the SPI command RAM.
package spi_ram_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned WORD_W = 10;
    localparam int unsigned OP_W   = 2;

    typedef enum logic [OP_W-1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_RD_ARMED = 2'b01,
        S_TX       = 2'b10
    } state_t;

endpackage

// File: rtl/spi_ram_array.sv
// Single-port 8-bit x MEM_DEPTH storage; the read register is the controller's tx_data.
module spi_ram_array
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_W-1:0]    din,
    output logic [DATA_W-1:0]    dout
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    // Synchronous write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
    end

    // Read path feeds the tx_data capture register in the controller.
    assign dout = r_mem[addr];

endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes 10-bit SPI command words into address loads, RAM writes and reads.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8,
    parameter bit          AUTO_INC  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              cmd_err
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_rx_valid_q;
    logic [ADDR_SIZE-1:0]   r_wr_addr;
    logic [ADDR_SIZE-1:0]   r_rd_addr;
    logic [DATA_W-1:0]      r_tx_data;
    logic                   r_tx_valid;
    logic                   r_cmd_err;

    logic                   w_accept;
    opcode_t                w_op;
    logic [ADDR_SIZE-1:0]   w_payload;
    logic                   w_addr_oor;
    logic [ADDR_SIZE-1:0]   w_wr_addr_inc;
    logic [ADDR_SIZE-1:0]   w_wr_addr_nxt;
    logic [ADDR_SIZE-1:0]   w_rd_addr_nxt;
    logic                   w_we;
    logic                   w_tx_load;
    logic                   w_tx_valid_nxt;
    logic                   w_cmd_err_nxt;
    logic [ADDR_SIZE-1:0]   w_mem_addr;
    logic [DATA_W-1:0]      w_mem_dout;

    // Rising edge of rx_valid is the single accept point per word.
    assign w_accept   = rx_valid & ~r_rx_valid_q;
    assign w_op       = opcode_t'(rx_data[WORD_W-1:WORD_W-OP_W]);
    assign w_payload  = rx_data[ADDR_SIZE-1:0];
    assign w_addr_oor = 32'(w_payload) >= MEM_DEPTH;

    // Write pointer wraps at MEM_DEPTH, not at the address width.
    assign w_wr_addr_inc = (r_wr_addr == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0
                                                                     : r_wr_addr + ADDR_SIZE'(1);

    // Shared RAM port: write address only while a write is in flight.
    assign w_mem_addr = (w_accept && (w_op == OP_WR_DATA)) ? r_wr_addr : r_rd_addr;

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk  (clk),
        .we   (w_we),
        .addr (w_mem_addr),
        .din  (rx_data[DATA_W-1:0]),
        .dout (w_mem_dout)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command decode: next state, address updates, read load and error pulse.
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_addr_nxt  = r_wr_addr;
        w_rd_addr_nxt  = r_rd_addr;
        w_we           = 1'b0;
        w_tx_load      = 1'b0;
        w_tx_valid_nxt = r_tx_valid;
        w_cmd_err_nxt  = 1'b0;

        if (w_accept) begin
            // Any accepted word consumes a pending read byte.
            if (r_state == S_TX) begin
                w_tx_valid_nxt = 1'b0;
            end

            unique case (w_op)
                OP_WR_ADDR: begin
                    if (w_addr_oor) begin
                        w_cmd_err_nxt = 1'b1;
                    end else begin
                        w_wr_addr_nxt = w_payload;
                        if (r_state == S_TX) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                OP_WR_DATA: begin
                    w_we = 1'b1;
                    if (AUTO_INC) begin
                        w_wr_addr_nxt = w_wr_addr_inc;
                    end
                    if (r_state == S_TX) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                OP_RD_ADDR: begin
                    if (w_addr_oor) begin
                        w_cmd_err_nxt = 1'b1;
                    end else begin
                        w_rd_addr_nxt = w_payload;
                        w_state_nxt   = S_RD_ARMED;
                    end
                end
                OP_RD_DATA: begin
                    if (r_state == S_RD_ARMED) begin
                        w_tx_load      = 1'b1;
                        w_tx_valid_nxt = 1'b1;
                        w_state_nxt    = S_TX;
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_valid_q <= 1'b0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_rx_valid_q <= rx_valid;
            r_wr_addr    <= w_wr_addr_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_tx_valid   <= w_tx_valid_nxt;
            r_cmd_err    <= w_cmd_err_nxt;
            if (w_tx_load) begin
                r_tx_data <= w_mem_dout;
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl (MEM_DEPTH=200, AUTO_INC=1).
module tb_spi_ram_ctrl;

    logic       clk;
    logic       rst_n;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       cmd_err;

    int checks;
    int failures;

    typedef struct {
        logic [9:0] rx;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    spi_ram_ctrl #(
        .MEM_DEPTH (200),
        .ADDR_SIZE (8),
        .AUTO_INC  (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .cmd_err  (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [9:0] rx, input logic v,
                                input logic [7:0] d, input logic e);
        vec_t t;
        t.rx        = rx;
        t.exp_valid = v;
        t.exp_data  = d;
        t.exp_err   = e;
        return t;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One word: rise rx_valid, sample one cycle later, then drop for a cycle.
    task automatic send(input logic [9:0] w, output logic v, output logic [7:0] d,
                        output logic e);
        rx_data  = w;
        rx_valid = 1'b1;
        @(negedge clk);
        v = tx_valid;
        d = tx_data;
        e = cmd_err;
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       v;
        logic [7:0] d;
        logic       e;

        checks   = 0;
        failures = 0;

        vecs[0]  = mk(10'h300, 1'b0, 8'h00, 1'b1);
        vecs[1]  = mk(10'h00A, 1'b0, 8'h00, 1'b0);
        vecs[2]  = mk(10'h15C, 1'b0, 8'h00, 1'b0);
        vecs[3]  = mk(10'h20A, 1'b0, 8'h00, 1'b0);
        vecs[4]  = mk(10'h300, 1'b1, 8'h5C, 1'b0);
        vecs[5]  = mk(10'h300, 1'b0, 8'h5C, 1'b1);
        vecs[6]  = mk(10'h20A, 1'b0, 8'h5C, 1'b0);
        vecs[7]  = mk(10'h300, 1'b1, 8'h5C, 1'b0);
        vecs[8]  = mk(10'h005, 1'b0, 8'h5C, 1'b0);
        vecs[9]  = mk(10'h300, 1'b0, 8'h5C, 1'b1);
        vecs[10] = mk(10'h0C7, 1'b0, 8'h5C, 1'b0);
        vecs[11] = mk(10'h111, 1'b0, 8'h5C, 1'b0);
        vecs[12] = mk(10'h122, 1'b0, 8'h5C, 1'b0);
        vecs[13] = mk(10'h0C8, 1'b0, 8'h5C, 1'b1);
        vecs[14] = mk(10'h133, 1'b0, 8'h5C, 1'b0);
        vecs[15] = mk(10'h2C7, 1'b0, 8'h5C, 1'b0);
        vecs[16] = mk(10'h300, 1'b1, 8'h11, 1'b0);
        vecs[17] = mk(10'h200, 1'b0, 8'h11, 1'b0);
        vecs[18] = mk(10'h300, 1'b1, 8'h22, 1'b0);
        vecs[19] = mk(10'h201, 1'b0, 8'h22, 1'b0);
        vecs[20] = mk(10'h300, 1'b1, 8'h33, 1'b0);
        vecs[21] = mk(10'h000, 1'b0, 8'h33, 1'b0);
        vecs[22] = mk(10'h2C8, 1'b0, 8'h33, 1'b1);
        vecs[23] = mk(10'h300, 1'b0, 8'h33, 1'b1);
        vecs[24] = mk(10'h2FF, 1'b0, 8'h33, 1'b1);

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (2) @(negedge clk);
        check("reset_tx_valid", 8'(tx_valid), 8'h00);
        check("reset_tx_data", tx_data, 8'h00);
        check("reset_cmd_err", 8'(cmd_err), 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].rx, v, d, e);
            check($sformatf("vec%0d_tx_valid", i), 8'(v), 8'(vecs[i].exp_valid));
            check($sformatf("vec%0d_tx_data", i), d, vecs[i].exp_data);
            check($sformatf("vec%0d_cmd_err", i), 8'(e), 8'(vecs[i].exp_err));
        end

        // cmd_err is a single-cycle pulse even with rx_valid held high.
        rx_data  = 10'h300;
        rx_valid = 1'b1;
        @(negedge clk);
        check("pulse_first", 8'(cmd_err), 8'h01);
        @(negedge clk);
        check("pulse_second", 8'(cmd_err), 8'h00);
        @(negedge clk);
        check("pulse_third", 8'(cmd_err), 8'h00);
        check("pulse_tx_valid", 8'(tx_valid), 8'h00);
        rx_valid = 1'b0;
        @(negedge clk);

        // Held rx_valid on a write yields one write and one increment.
        send(10'h003, v, d, e);
        rx_data  = 10'h1AA;
        rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        send(10'h1BB, v, d, e);
        send(10'h203, v, d, e);
        send(10'h300, v, d, e);
        check("held_mem3_valid", 8'(v), 8'h01);
        check("held_mem3_data", d, 8'hAA);
        send(10'h204, v, d, e);
        send(10'h300, v, d, e);
        check("held_mem4_data", d, 8'hBB);

        // Asynchronous reset clears outputs before the next clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_tx_valid", 8'(tx_valid), 8'h00);
        check("areset_tx_data", tx_data, 8'h00);
        check("areset_cmd_err", 8'(cmd_err), 8'h00);
        rx_data  = 10'h300;
        rx_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_accept_err", 8'(cmd_err), 8'h01);
        rx_valid = 1'b0;
        @(negedge clk);

        // wr_addr restarts at zero after reset.
        send(10'h144, v, d, e);
        send(10'h200, v, d, e);
        send(10'h300, v, d, e);
        check("post_reset_wr0_valid", 8'(v), 8'h01);
        check("post_reset_wr0_data", d, 8'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
